// File: rtl/nand_stim_pkg.sv
// Shared types and constants for the NAND stimulus generator.
// Holds the sequencer state enum and the checker saturation limit.
package nand_stim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/nand_stim_gen_toggler.sv
// Half-period counter plus toggle flop; one instance drives A, one drives B.
// fall is combinational: high on the edge that will take q from 1 to 0.
module half_period_toggler #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic [CNT_W-1:0] half,
    output logic             q,
    output logic             fall
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = en && (cnt == half - ONE);
    assign fall = wrap && q;

    // Count cycles while enabled; toggle q and restart at the half period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            q   <= ~q;
        end else if (en) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/nand_stim_gen.sv
// A/B sweep generator for the two-input NAND cell with start/busy/done.
// Define NAND_STIM_CHECK_EN to add the out1 checker (out1, err_cnt, err).
module nand_stim_gen
    import nand_stim_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] half_a,
    input  logic [CNT_W-1:0] half_b,
    input  logic [REP_W-1:0] reps,
    output logic             A,
    output logic             B,
    output logic             busy,
    output logic             done
`ifdef NAND_STIM_CHECK_EN
   ,input  logic             out1,
    output logic [7:0]       err_cnt,
    output logic             err
`endif
);

    localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] half_a_q;
    logic [CNT_W-1:0] half_b_q;
    logic [REP_W-1:0] reps_q;
    logic [REP_W-1:0] rep_cnt;
    logic             launch;
    logic             zero;
    logic             last;
    logic             run;
    logic             fall_a;
    logic             fall_b;

    assign run    = (state == RUN);
    assign launch = (state == IDLE) && start;
    assign zero   = (half_a == '0) || (half_b == '0) || (reps == '0);
    assign last   = run && fall_b && (rep_cnt == reps_q - REP_ONE);
    assign busy   = run;
    assign done   = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next state: zero-parameter launches skip straight to DONE.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = zero ? DONE : RUN;
            RUN:     if (last) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Latch the run parameters at launch; count B falling edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_a_q <= '0;
            half_b_q <= '0;
            reps_q   <= '0;
            rep_cnt  <= '0;
        end else if (launch) begin
            half_a_q <= half_a;
            half_b_q <= half_b;
            reps_q   <= reps;
            rep_cnt  <= '0;
        end else if (run && fall_b) begin
            rep_cnt  <= rep_cnt + REP_ONE;
        end
    end

    // Clearing on the final edge forces A low together with B's last fall.
    half_period_toggler #(.CNT_W(CNT_W)) u_tog_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .clear (!run || last),
        .half  (half_a_q),
        .q     (A),
        .fall  (fall_a)
    );

    half_period_toggler #(.CNT_W(CNT_W)) u_tog_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .clear (!run || last),
        .half  (half_b_q),
        .q     (B),
        .fall  (fall_b)
    );

`ifdef NAND_STIM_CHECK_EN
    logic a_q;
    logic b_q;
    logic run_q;

    // One-cycle copies of A/B so out1 is judged against the inputs it saw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= 1'b0;
            b_q   <= 1'b0;
            run_q <= 1'b0;
        end else begin
            a_q   <= A;
            b_q   <= B;
            run_q <= run;
        end
    end

    // Count mismatches of out1 against the delayed NAND, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            err     <= 1'b0;
        end else if (launch) begin
            err_cnt <= '0;
            err     <= 1'b0;
        end else if (run_q && (out1 != ~(a_q & b_q))) begin
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 8'd1;
            err <= 1'b1;
        end
    end
`else
    logic unused;
    assign unused = fall_a;
`endif

endmodule

// File: tb/tb_nand_stim_gen.sv
// Randomized bench for nand_stim_gen with an in-bench sweep model.
// Expected waveforms are derived from k/half arithmetic per launch.
module tb_nand_stim_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] half_a = '0;
    logic [15:0] half_b = '0;
    logic [7:0]  reps = '0;
    logic        A, B, busy, done;
    logic        out1 = 1'b1;
    logic [7:0]  err_cnt;
    logic        err;
    int          mode = 0;

    int n_chk = 0;
    int n_fail = 0;

    nand_stim_gen #(.CNT_W(16), .REP_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .half_a  (half_a),
        .half_b  (half_b),
        .reps    (reps),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done)
`ifdef NAND_STIM_CHECK_EN
       ,.out1    (out1),
        .err_cnt (err_cnt),
        .err     (err)
`endif
    );

`ifndef NAND_STIM_CHECK_EN
    assign err_cnt = '0;
    assign err = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // NAND response driven into the checker: delayed good, stuck 1, random.
    always @(posedge clk) begin
        if (mode == 0)      out1 <= ~(A & B);
        else if (mode == 1) out1 <= 1'b1;
        else                out1 <= 1'($urandom % 2);
    end

    // Model: cycle k of an active run; m_last is the done cycle index.
    int m_on, m_k, m_last, m_ha, m_hb;
    int e_cnt, e_flag, p_busy, p_ab;

    function automatic logic [3:0] model_out();
        logic a, b;
        if (m_on == 0) return 4'b0000;
        if (m_k == m_last) return 4'b0100;
        a = ((m_k / m_ha) % 2) == 1;
        b = ((m_k / m_hb) % 2) == 1;
        return {1'b1, 1'b0, a, b};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] cur;
        if (!rst_n) begin
            m_on <= 0; m_k <= 0; m_last <= 0; m_ha <= 1; m_hb <= 1;
            e_cnt <= 0; e_flag <= 0; p_busy <= 0; p_ab <= 0;
        end else begin
            cur = model_out();
            if (p_busy == 1 && out1 != !p_ab) begin
                if (e_cnt < 255) e_cnt <= e_cnt + 1;
                e_flag <= 1;
            end
            p_busy <= int'(cur[3]);
            p_ab <= int'(cur[1] & cur[0]);
            if (m_on == 0) begin
                if (start) begin
                    m_on <= 1;
                    m_k <= 0;
                    m_ha <= int'(half_a);
                    m_hb <= int'(half_b);
                    if (half_a == 0 || half_b == 0 || reps == 0) m_last <= 0;
                    else m_last <= 2 * int'(reps) * int'(half_b);
                    e_cnt <= 0;
                    e_flag <= 0;
                end
            end else if (m_k == m_last) begin
                m_on <= 0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    // Compare every cycle against the model.
    always @(negedge clk) begin
        logic [3:0] e;
        e = model_out();
        chk("busy", int'(busy), int'(e[3]));
        chk("done", int'(done), int'(e[2]));
        chk("A", int'(A), int'(e[1]));
        chk("B", int'(B), int'(e[0]));
`ifdef NAND_STIM_CHECK_EN
        chk("err_cnt", int'(err_cnt), e_cnt);
        chk("err", int'(err), e_flag);
`endif
    end

    task automatic launch(input int ha, input int hb, input int rp);
        @(posedge clk); #1;
        start = 1'b1;
        half_a = 16'(ha);
        half_b = 16'(hb);
        reps = 8'(rp);
        @(posedge clk); #1;
        start = 1'b0;
        half_a = 16'($urandom);
        half_b = 16'($urandom);
        reps = 8'($urandom);
    endtask

    task automatic wait_done(input int budget, input int spam);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (done) begin
                start = 1'b0;
                break;
            end
            start = (spam != 0) && busy && ($urandom % 4 == 0);
            n++;
            if (n >= budget) begin
                start = 1'b0;
                n_chk++;
                n_fail++;
                $display("FAIL timeout: no done within %0d cycles", budget);
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] av, bv;
        int nb, nd, nf, pb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_AB", int'({A, B}), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        mode = 1;
        launch(2, 4, 1);
        av = '0; bv = '0; nb = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            av[k] = A;
            bv[k] = B;
            nb += int'(busy);
        end
        chk("dir1_A", int'(av), 8'hCC);
        chk("dir1_B", int'(bv), 8'hF0);
        chk("dir1_busy", nb, 8);
        @(negedge clk);
        chk("dir1_done", int'(done), 1);
        chk("dir1_done_AB", int'({A, B, busy}), 0);
        @(negedge clk);
        chk("dir1_one_pulse", int'(done), 0);
`ifdef NAND_STIM_CHECK_EN
        chk("dir1_err_cnt", int'(err_cnt), 2);
        chk("dir1_err", int'(err), 1);
`endif

        mode = 0;
        launch(1, 2, 3);
        nb = 0; nd = 0; nf = 0; pb = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
`ifdef NAND_STIM_CHECK_EN
            if (k == 0) chk("dir2_err_clr", int'({err, err_cnt}), 0);
`endif
            nb += int'(busy);
            nd += int'(done);
            if (pb == 1 && B == 1'b0) nf++;
            pb = int'(B);
            start = (k == 4);
        end
        start = 1'b0;
        chk("dir2_busy", nb, 12);
        chk("dir2_falls", nf, 3);
        chk("dir2_done", nd, 1);

        launch(3, 3, 0);
        @(negedge clk);
        chk("zero_reps_done", int'(done), 1);
        chk("zero_reps_busy", int'(busy), 0);
        launch(0, 2, 2);
        @(negedge clk);
        chk("zero_ha_done", int'(done), 1);
        @(negedge clk);
        chk("zero_ha_after", int'(done), 0);

        mode = 2;
        launch(2, 4, 4);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("arst_outs", int'({busy, done, A, B}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            nd += int'(done);
        end
        chk("arst_no_done", nd, 0);
        mode = 0;
        launch(2, 4, 1);
        wait_done(200, 0);

        for (int i = 0; i < 40; i++) begin
            int ha, hb, rp;
            ha = ($urandom % 10 == 0) ? 0 : int'($urandom_range(1, 4));
            hb = int'($urandom_range(1, 5));
            rp = int'($urandom_range(0, 3));
            mode = int'($urandom % 3);
            launch(ha, hb, rp);
            wait_done(500, 1);
            repeat ($urandom % 3) @(posedge clk);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nand_stim_gen.md
# nand_stim_gen

Upstream stimulus stage for the two-input CMOS NAND cell. Generates the A/B square-wave pair (B at half A's frequency by default, giving an exhaustive 00→10→01→11 sweep), runs a programmed number of sweeps under a start/busy/done handshake, and optionally checks the cell's output against ~(A&B).

## Interface
Parameters:
- CNT_W, 16, width of half-period counters and the half_a/half_b inputs
- REP_W, 8, width of the sweep-count input

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch request, sampled in IDLE only
- half_a  in  CNT_W  A half-period in clk cycles
- half_b  in  CNT_W  B half-period in clk cycles
- reps  in  REP_W  number of full B periods to generate
- A  out  1  stimulus to NAND input A
- B  out  1  stimulus to NAND input B
- busy  out  1  high while RUN
- done  out  1  one-cycle completion pulse
- out1  in  1  NAND output (NAND_STIM_CHECK_EN only)
- err_cnt  out  8  saturating mismatch count (NAND_STIM_CHECK_EN only)
- err  out  1  sticky mismatch flag (NAND_STIM_CHECK_EN only)

Reset values: A=0, B=0, busy=0, done=0, err_cnt=0, err=0; state IDLE; all counters 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: A=B=0. On start=1, latch half_a, half_b, reps.
  - If any latched value is 0: go to DONE directly; no toggles.
  - Otherwise: go to RUN; cnt_a=cnt_b=0; rep_cnt=0.
- RUN, per edge:
  - cnt_a increments; at half_a-1 it wraps to 0 and A toggles.
  - cnt_b/B behave the same with half_b.
  - Each B 1→0 transition increments rep_cnt.
  - The edge producing the reps-th B fall transitions to DONE, and A is forced 0 on that same edge.
- DONE: lasts one cycle, done=1, busy=0, A=B=0, then IDLE.
- start in RUN or DONE is ignored, not queued.
- half_a/half_b/reps inputs are don't-care except at launch.
- Counter compares are unsigned, full CNT_W; half=1 means toggle every cycle.
- Asynchronous reset mid-RUN returns all outputs to reset values immediately; no done pulse.

## Timing
- start sampled at edge t: busy=1 after t; A,B remain 0.
- A first rises after edge t+half_a; B first rises after edge t+half_b.
- done=1 for the cycle following edge t+2·reps·half_b; busy=0 in that cycle.
- Next start is accepted at the earliest in the cycle after done, i.e. while in IDLE.
- Zero-parameter launch: done=1 in the cycle after edge t; busy never asserts.

## Configuration
- NAND_STIM_CHECK_EN defined: out1, err_cnt, err ports exist.
  - A_q/B_q register A/B each cycle.
  - In every RUN cycle except the first after launch, out1 is compared with ~(A_q&B_q).
  - On a mismatch, err_cnt increments (saturating at 255) and err sets.
  - Both clear on an accepted start.
- Undefined: the three ports and all checker logic are absent; behaviour otherwise identical.

## Structure
- Package nand_stim_pkg holds the state enum (IDLE/RUN/DONE) and the ERR_MAX=255 constant.
- Sub-module half_period_toggler: counter plus toggle flop, inputs en/half/clear, outputs q and fall pulse. It is instantiated twice, for A and B.

## Test plan
- half_a=2, half_b=4, reps=1, start pulse: A=0,0,1,1,0,0,1,1 and B=0,0,0,0,1,1,1,1 over 8 busy cycles, then done=1 for exactly one cycle with A=B=0.
- half_a=1, half_b=2, reps=3: 12 busy cycles, 3 B falls, single done pulse; start asserted mid-run is ignored.
- reps=0 (or half_a=0): busy stays 0, done=1 the cycle after start, A/B never toggle.
- rst_n low at cycle 5 of a half_a=2,half_b=4,reps=4 run: A=B=busy=0 immediately, no done pulse; a new start then runs normally.
- CHECK_EN with out1 tied to ~(A&B) delayed by 1 cycle: err_cnt=0, err=0 at done.
- CHECK_EN with out1 stuck 1, half_a=2, half_b=4, reps=1: err_cnt=2 (the AB=11 cycles), err=1; next start clears both.
